// File: rtl/dout_uart_tx_pkg.sv
// Shared definitions for the Dout/Dval UART transmitter: FSM state
// encodings, frame line levels and the default bit-period divisor.
package dout_uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int   DATA_BITS       = 8;
   localparam logic STOP_LEVEL      = 1'b1;
   localparam logic IDLE_LEVEL      = 1'b1;
   localparam int   DEFAULT_DIVISOR = 434;   // 50 MHz / 115200 baud
   localparam int   DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/dout_uart_tx_baud_tick.sv
// Bit-period counter (the baud_tick block of dout_uart_tx). Counts
// 0..DIVISOR-1 while enabled and pulses tick on the last cycle of each bit.
// clear restarts the period so a new frame always begins on a full bit.
module dout_uart_tx_baud_tick
   import dout_uart_tx_pkg::*;
#(
   parameter int DIVISOR = DEFAULT_DIVISOR,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // Period counter: held at zero when idle or cleared, wraps on tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || !enable || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dout_uart_tx.sv
// UART transmitter hung off the CPU Dout/Dval outputs. Detects each new
// output byte, keeps one byte in a holding register and sends 8N1 frames
// LSB first. Define DOUT_TX_PARITY_EN to insert an even-parity bit (8E1).
module dout_uart_tx
   import dout_uart_tx_pkg::*;
#(
   parameter int DIVISOR = DEFAULT_DIVISOR,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Dout,
   input  logic       Dval,
   output logic       Tx,
   output logic       Busy,
   output logic       Overrun
);

   tx_state_t  state, state_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shifter, shifter_n;
   logic [7:0] hold_byte, hold_byte_n;
   logic       hold_full, hold_full_n;
   logic [7:0] last_byte;
   logic       dval_q;
   logic       overrun_n;
   logic       tx_n;
   logic       load_evt;
   logic       start_frame;
   logic       tick;

   // A new byte: Dval rising, or Dval steady with a different value.
   assign load_evt = Dval && (!dval_q || (Dout != last_byte));

   dout_uart_tx_baud_tick #(
      .DIVISOR (DIVISOR),
      .CNT_W   (CNT_W)
   ) u_baud_tick (
      .clk    (Clock),
      .rst    (Reset),
      .clear  (start_frame),
      .enable (state != ST_IDLE),
      .tick   (tick)
   );

   // Next-state logic: frame sequencing, then routing of a new byte.
   always_comb begin
      state_n     = state;
      bit_idx_n   = bit_idx;
      shifter_n   = shifter;
      hold_byte_n = hold_byte;
      hold_full_n = hold_full;
      overrun_n   = Overrun;
      start_frame = 1'b0;
      case (state)
         ST_IDLE: begin
            // A byte parked while STOP was ending is picked up here.
            if (hold_full) begin
               shifter_n   = hold_byte;
               hold_full_n = 1'b0;
               state_n     = ST_START;
               start_frame = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_n   = ST_DATA;
               bit_idx_n = 3'd0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef DOUT_TX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
`ifdef DOUT_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_n = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (hold_full) begin
                  // Back-to-back: next START begins on the very next cycle.
                  shifter_n   = hold_byte;
                  hold_full_n = 1'b0;
                  state_n     = ST_START;
                  start_frame = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Routing decisions use the occupancy seen before this edge.
      if (load_evt) begin
         if ((state == ST_IDLE) && !hold_full) begin
            shifter_n   = Dout;
            state_n     = ST_START;
            start_frame = 1'b1;
         end else if (!hold_full) begin
            hold_byte_n = Dout;
            hold_full_n = 1'b1;
         end else begin
            overrun_n = 1'b1;
         end
      end
   end

   // Line level for the bit currently being timed; registered into Tx.
   always_comb begin
      tx_n = IDLE_LEVEL;
      case (state)
         ST_START:  tx_n = 1'b0;
         ST_DATA:   tx_n = shifter[bit_idx];
`ifdef DOUT_TX_PARITY_EN
         ST_PARITY: tx_n = ^shifter;
`endif
         ST_STOP:   tx_n = STOP_LEVEL;
         default:   tx_n = IDLE_LEVEL;
      endcase
   end

   // State, buffers, change detector and registered outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         bit_idx   <= 3'd0;
         shifter   <= 8'h00;
         hold_byte <= 8'h00;
         hold_full <= 1'b0;
         last_byte <= 8'h00;
         dval_q    <= 1'b0;
         Overrun   <= 1'b0;
         Busy      <= 1'b0;
         Tx        <= IDLE_LEVEL;
      end else begin
         state     <= state_n;
         bit_idx   <= bit_idx_n;
         shifter   <= shifter_n;
         hold_byte <= hold_byte_n;
         hold_full <= hold_full_n;
         dval_q    <= Dval;
         if (load_evt) begin
            last_byte <= Dout;
         end
         Overrun   <= overrun_n;
         Busy      <= (state != ST_IDLE) || hold_full;
         Tx        <= tx_n;
      end
   end

endmodule

// File: tb/tb_dout_uart_tx.sv
// Bench for dout_uart_tx with DIVISOR=4. Stimulus pushes each byte that
// must appear on the line into exp_q; a line monitor decodes frames from Tx
// and compares them against the queue.
module tb_dout_uart_tx;

   localparam int DIV   = 4;
   localparam int CNT_W = 16;
`ifdef DOUT_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [7:0] dout = 8'h00;
   logic       dval = 1'b0;
   logic       tx;
   logic       busy;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int frames   = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];

   dout_uart_tx #(
      .DIVISOR (DIV),
      .CNT_W   (CNT_W)
   ) dut (
      .Clock   (clk),
      .Reset   (rst),
      .Dout    (dout),
      .Dval    (dval),
      .Tx      (tx),
      .Busy    (busy),
      .Overrun (overrun)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 400) begin
         n_fail++;
         $display("FAIL %s: busy=%b pending=%0d after %0d cycles, required idle", name, busy, exp_q.size(), t);
      end
      tick(2);
   endtask

   // Send one byte from a quiet Dval and time its frame.
   task automatic send_measure(input logic [7:0] b);
      int n;
      dout = b;
      dval = 1'b1;
      exp_q.push_back(b);
      tick(1);
      check_bit("latency_tx_high", tx, 1'b1);
      tick(1);
      check_bit("latency_tx_low", tx, 1'b0);
      check_bit("latency_busy_high", busy, 1'b1);
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick(1);
      end
      check32("busy_width", 32'(n), 32'(NBITS * DIV));
      dval = 1'b0;
      wait_idle("measure_idle");
   endtask

   task automatic check_gap(input string name);
      check32({name, "_frame_count"}, 32'(start_q.size()), 32'd2);
      if (start_q.size() == 2) begin
         check32({name, "_start_spacing"}, 32'(start_q[1] - start_q[0]), 32'(NBITS * DIV));
      end
   endtask

   // Line monitor: decode each frame bit-by-bit and score it.
   initial begin : monitor
      logic             prev_tx;
      logic [NBITS-1:0] bits;
      logic             stable;
      logic             aborted;
      logic [7:0]       e;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_tx = 1'b1;
            continue;
         end
         if (prev_tx && !tx) begin
            start_q.push_back(cyc);
            bits    = '0;
            stable  = 1'b1;
            aborted = 1'b0;
            for (int j = 0; j < NBITS; j++) begin
               for (int c = 0; c < DIV; c++) begin
                  if (!(j == 0 && c == 0)) @(negedge clk);
                  if (rst) aborted = 1'b1;
                  if (aborted) break;
                  if (c == 0) bits[j] = tx;
                  else if (tx !== bits[j]) stable = 1'b0;
               end
               if (aborted) break;
            end
            if (!aborted) begin
               frames++;
               check_bit("frame_bits_stable", stable, 1'b1);
               check_bit("frame_start_bit", bits[0], 1'b0);
               check_bit("frame_stop_bit", bits[NBITS-1], 1'b1);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got byte 0x%0h, required no frame", bits[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  check32("frame_byte", 32'(bits[8:1]), 32'(e));
`ifdef DOUT_TX_PARITY_EN
                  check_bit("frame_parity", bits[9], ^e);
`endif
               end
            end
            prev_tx = 1'b1;
         end else begin
            prev_tx = tx;
         end
      end
   end

   // Directed stimulus
   initial begin : stim
      int t;
      int f0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      check_bit("reset_tx", tx, 1'b1);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_overrun", overrun, 1'b0);

      // Single frame 0xA5: latency, bit pattern, Busy width
      send_measure(8'hA5);

      // Two bytes inside one frame: back-to-back, no overrun
      start_q.delete();
      dout = 8'h11; dval = 1'b1; exp_q.push_back(8'h11);
      tick(12);
      dout = 8'h22; exp_q.push_back(8'h22);
      wait_idle("b2b_idle");
      check_bit("b2b_overrun", overrun, 1'b0);
      check_gap("b2b");
      dval = 1'b0;
      tick(1);

      // Three bytes inside one frame: third dropped, Overrun sticky
      start_q.delete();
      dout = 8'h11; dval = 1'b1; exp_q.push_back(8'h11);
      tick(8);
      dout = 8'h22; exp_q.push_back(8'h22);
      tick(8);
      dout = 8'h33;
      tick(2);
      check_bit("drop_overrun_set", overrun, 1'b1);
      wait_idle("drop_idle");
      check_bit("drop_overrun_sticky", overrun, 1'b1);
      check_gap("drop");
      dval = 1'b0;
      tick(1);

      // Constant byte with Dval held: exactly one frame
      f0 = frames;
      dout = 8'h5A; dval = 1'b1; exp_q.push_back(8'h5A);
      tick(200);
      wait_idle("const_idle");
      check32("const_one_frame", 32'(frames - f0), 32'd1);
      dval = 1'b0;
      tick(1);

      // Reset during DATA bit 3, then a clean frame of 0x00
      dout = 8'hC3; dval = 1'b1;
      t = 0;
      while (tx && t < 20) begin
         tick(1);
         t++;
      end
      check_bit("abort_frame_started", tx, 1'b0);
      tick(17);
      rst = 1'b1;
      dval = 1'b0;
      #1;
      check_bit("abort_tx", tx, 1'b1);
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_overrun", overrun, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(2);
      check_bit("after_abort_tx", tx, 1'b1);
      check_bit("after_abort_busy", busy, 1'b0);
      send_measure(8'h00);
      check_bit("after_abort_overrun", overrun, 1'b0);

`ifdef DOUT_TX_PARITY_EN
      // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0
      send_measure(8'h07);
      send_measure(8'h03);
`endif

      tick(5);
      check32("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
